c_smag_sub_seq: RTL and testbench

C_SMAG_SUB_SEQ -- requirements
Module: c_smag_sub_seq

---
 rtl/c_smag_sub_seq.sv | 132 +++++++++++++
 tb/tb_c_smag_sub_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_smag_sub_seq.sv
// Sequential sign-magnitude subtractor: 32-bit operands, magnitude processed 8 bits per cycle.
// Define C_SMAG_SUB_ADDSUB_OP_EN to add an 'op' input (1 = add, 0 = subtract).
module c_smag_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
`ifdef C_SMAG_SUB_ADDSUB_OP_EN
  input  logic        op,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_reg;
  logic [1:0]  cnt_reg;
  logic [31:0] n1_reg, n2_reg;
  logic        op_reg;
  logic [31:0] a_reg, b_reg, res_reg;
  logic        s1_reg, s2_reg, gt_reg, eq_reg, carry_reg;
  logic [31:0] diff_reg;
  logic        ovf_reg;

  logic [30:0] mag1, mag2;
  logic        s1_eff, s2_eff, gt_c, eq_c, sub_c, sub_w;
  logic [7:0]  b8;
  logic [8:0]  sum9;
  logic [31:0] final_w;
  logic [30:0] mag_w;
  logic        sign_w;

  // CMP stage: effective signs (zero magnitude is always positive) and magnitude compare
  assign mag1   = n1_reg[30:0];
  assign mag2   = n2_reg[30:0];
  assign s1_eff = n1_reg[31] & (|mag1);
  assign s2_eff = (n2_reg[31] ^ ~op_reg) & (|mag2);
  assign gt_c   = mag1 > mag2;
  assign eq_c   = mag1 == mag2;
  assign sub_c  = s1_eff ^ s2_eff;

  // CALC stage: one 8-bit chunk per cycle, subtraction as a + ~b + 1 with the carry kept in carry_reg
  assign sub_w   = s1_reg ^ s2_reg;
  assign b8      = sub_w ? ~b_reg[7:0] : b_reg[7:0];
  assign sum9    = {1'b0, a_reg[7:0]} + {1'b0, b8} + {8'd0, carry_reg};
  assign final_w = {sum9[7:0], res_reg[31:8]};
  assign mag_w   = final_w[30:0];
  assign sign_w  = sub_w ? (eq_reg ? 1'b0 : (gt_reg ? s1_reg : s2_reg)) : s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      n1_reg    <= 32'd0;
      n2_reg    <= 32'd0;
      op_reg    <= 1'b0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      res_reg   <= 32'd0;
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      gt_reg    <= 1'b0;
      eq_reg    <= 1'b0;
      carry_reg <= 1'b0;
      diff_reg  <= 32'd0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            n1_reg    <= num1;
            n2_reg    <= num2;
`ifdef C_SMAG_SUB_ADDSUB_OP_EN
            op_reg    <= op;
`else
            op_reg    <= 1'b0;
`endif
            state_reg <= CMP;
          end
        end
        CMP: begin
          s1_reg    <= s1_eff;
          s2_reg    <= s2_eff;
          gt_reg    <= gt_c;
          eq_reg    <= eq_c;
          carry_reg <= sub_c;
          // For subtraction the larger magnitude always goes into a_reg
          if (sub_c && !gt_c) begin
            a_reg <= {1'b0, mag2};
            b_reg <= {1'b0, mag1};
          end else begin
            a_reg <= {1'b0, mag1};
            b_reg <= {1'b0, mag2};
          end
          res_reg   <= 32'd0;
          cnt_reg   <= 2'd0;
          state_reg <= CALC;
        end
        CALC: begin
          a_reg     <= {8'd0, a_reg[31:8]};
          b_reg     <= {8'd0, b_reg[31:8]};
          res_reg   <= final_w;
          carry_reg <= sum9[8];
          cnt_reg   <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            // Bit 31 of the padded sum is the carry out of bit 30
            diff_reg  <= {sign_w & (|mag_w), mag_w};
            ovf_reg   <= ~sub_w & final_w[31];
            state_reg <= DONE;
          end
        end
        default: begin
          if (out_ready) state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) & rst_n;
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_c_smag_sub_seq.sv
// Testbench for c_smag_sub_seq: scoreboard of expected {diff, ovf} checked when out_valid appears.
module tb_c_smag_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num1 = 32'd0;
  logic [31:0] num2 = 32'd0;
`ifdef C_SMAG_SUB_ADDSUB_OP_EN
  logic        op = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  c_smag_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
`ifdef C_SMAG_SUB_ADDSUB_OP_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .ovf       (ovf)
  );

  // Reference: signed integer difference, magnitude wrapped to 31 bits
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint v1, v2, d, ad;
    logic [30:0] m;
    logic ov, sg;
    v1 = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    v2 = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    d  = v1 - v2;
    ad = (d < 0) ? -d : d;
    m  = ad[30:0];
    ov = (ad >= 64'sh80000000);
    sg = (d < 0);
    return {((m == 31'd0) ? 32'h0 : {sg, m}), ov};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_o, input int hold);
    int w, lat;
    logic [32:0] e;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
    end
    num1 = a; num2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back({exp_d, exp_o});
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: in_ready=%b required 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL latency: edges=%0d required 5", lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (diff !== e[32:1] || ovf !== e[0]) begin
      errors++;
      $display("FAIL result %h-%h: diff=%h ovf=%b required diff=%h ovf=%b", a, b, diff, ovf, e[32:1], e[0]);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (diff !== e[32:1] || ovf !== e[0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold: diff=%h ovf=%b in_ready=%b out_valid=%b required %h %b 0 1",
                 diff, ovf, in_ready, out_valid, e[32:1], e[0]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== e[32:1] || ovf !== e[0]) begin
      errors++;
      $display("FAIL retire: out_valid=%b in_ready=%b diff=%h required 0 1 %h", out_valid, in_ready, diff, e[32:1]);
    end
    $display("op num1=%h num2=%h -> diff=%h ovf=%b (expected %h %b)", a, b, diff, ovf, e[32:1], e[0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || diff !== 32'h0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b diff=%h ovf=%b in_ready=%b required 0 0 0 0", out_valid, diff, ovf, in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
    $display("reset: out_valid=%b diff=%h in_ready=%b", out_valid, diff, in_ready);
  endtask

  task automatic test_vectors;
    run_op(32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 0);
    run_op(32'h00000003, 32'h00000005, 32'h80000002, 1'b0, 0);
    run_op(32'h80000004, 32'h00000004, 32'h80000008, 1'b0, 0);
    run_op(32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 0);
    run_op(32'h7FFFFFFF, 32'h80000001, 32'h00000000, 1'b1, 0);
    run_op(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 0);
    run_op(32'h80000000, 32'h00000009, 32'h80000009, 1'b0, 0);
    run_op(32'h40000000, 32'hC0000001, 32'h00000001, 1'b1, 0);
    run_op(32'h80000100, 32'h800000FF, 32'h80000001, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [32:0] e;
    for (int i = 0; i < 16; i++) begin
      a = $urandom();
      b = $urandom();
      if (i % 4 == 1) b = {~a[31], a[30:0]};
      if (i % 4 == 2) b = {a[31], a[30:8], $urandom_range(0, 255)};
      e = model(a, b);
      run_op(a, b, e[32:1], e[0], i % 3);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [32:0] e;
    run_op(32'h12345678, 32'h00000078, 32'h12345600, 1'b0, 3);
    num1 = 32'h00001000; num2 = 32'h00000001;
    in_valid = 1'b1;
    while (!in_ready) tick();
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (diff !== 32'h00000FFF || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: diff=%h in_ready=%b out_valid=%b required 00000fff 0 1", diff, in_ready, out_valid);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    num1 = 32'h00000007; num2 = 32'h00000002;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire_no_accept: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    sb_q.push_back({32'h00000005, 1'b0});
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL next_accept: in_ready=%b required 0", in_ready);
    end
    wait_out(lat);
    e = sb_q.pop_front();
    checks++;
    if (lat != 5 || diff !== e[32:1] || ovf !== e[0]) begin
      errors++;
      $display("FAIL bp_result: edges=%0d diff=%h ovf=%b required 5 %h %b", lat, diff, ovf, e[32:1], e[0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("backpressure: late accept diff=%h ovf=%b", diff, ovf);
  endtask

  task automatic test_back_to_back;
    run_op(32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 0);
    run_op(32'h80000010, 32'h80000020, 32'h00000010, 1'b0, 0);
    run_op(32'h00FF00FF, 32'h80FF00FF, 32'h01FE01FE, 1'b0, 0);
  endtask

  task automatic test_reset_mid_calc;
    int seen;
    run_op(32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 0);
    num1 = 32'h00000100; num2 = 32'h00000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back({32'h000000FF, 1'b0});
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 32'h0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b diff=%h ovf=%b in_ready=%b required 0 0 0 0", out_valid, diff, ovf, in_ready);
    end
    void'(sb_q.pop_front());
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release: in_ready=%b required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_result: out_valid cycles=%0d required 0", seen);
    end
    $display("reset mid-CALC: diff=%h in_ready=%b stale=%0d", diff, in_ready, seen);
    run_op(32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
